// File: rtl/scoreboard_pkg.sv
// Shared types for the top-N score table: entry layout, FSM encoding and the rank-compare helper.
// Optional feature macro used by the top: SCOREBOARD_CLEAR_EN.
package scoreboard_pkg;

    localparam int SB_SCORE_W = 32;
    localparam int SB_UID_W   = 16;

    typedef struct packed {
        logic                  valid;
        logic [SB_UID_W-1:0]   userid;
        logic [SB_SCORE_W-1:0] score;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_INSERT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A new score outranks a slot only if the slot is empty or strictly lower; ties keep the incumbent.
    function automatic logic slot_hit(input entry_t slot, input logic [SB_SCORE_W-1:0] new_score);
        return (!slot.valid) || (new_score > slot.score);
    endfunction

endpackage

// File: rtl/scoreboard_slot.sv
// One ranked table entry: holds, takes the entry from the slot above, or loads the new result.
module scoreboard_slot
    import scoreboard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   load_en,
    input  logic   shift_en,
    input  entry_t above,
    input  entry_t new_entry,
    output entry_t entry
);

    entry_t entry_r;

    // Entry register: clear beats load, load beats shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_r <= '0;
        end else if (clr) begin
            entry_r <= '0;
        end else if (load_en) begin
            entry_r <= new_entry;
        end else if (shift_en) begin
            entry_r <= above;
        end else begin
            entry_r <= entry_r;
        end
    end

    assign entry = entry_r;

endmodule

// File: rtl/scoreboard_ranker.sv
// Top-N (userid, score) table kept in descending score order, filled by a linear scan-then-insert FSM.
// Define SCOREBOARD_CLEAR_EN to add the synchronous clr input that empties the table and aborts inserts.
module scoreboard_ranker
    import scoreboard_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int SCORE_W   = SB_SCORE_W,
    parameter int UID_W     = SB_UID_W,
    parameter int IDX_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SCOREBOARD_CLEAR_EN
    input  logic               clr,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    input  logic [UID_W-1:0]   in_userid,
    output logic               ins_done,
    output logic [IDX_W-1:0]   ins_rank,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [SCORE_W-1:0] rd_score,
    output logic [UID_W-1:0]   rd_userid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_ENTRIES);

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   pos_r;
    entry_t             new_r;
    logic               in_ready_r;
    logic               ins_done_r;
    logic [IDX_W-1:0]   ins_rank_r;
    logic               rd_valid_r;
    logic [SCORE_W-1:0] rd_score_r;
    logic [UID_W-1:0]   rd_userid_r;

    entry_t             slot_q     [N_ENTRIES];
    entry_t             above_s    [N_ENTRIES];
    logic [N_ENTRIES-1:0] load_en_s;
    logic [N_ENTRIES-1:0] shift_en_s;
    entry_t             scan_sel_s;
    entry_t             rd_sel_s;
    logic               hit_s;
    logic               ins_hit_s;
    logic               clr_s;

`ifdef SCOREBOARD_CLEAR_EN
    assign clr_s = clr;
`else
    assign clr_s = 1'b0;
`endif

    // Slot currently under comparison during the scan.
    always_comb begin
        scan_sel_s = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            scan_sel_s = (idx_r == IDX_W'(i)) ? slot_q[i] : scan_sel_s;
        end
    end

    // Slot addressed by the read port; out-of-range indices select nothing.
    always_comb begin
        rd_sel_s = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            rd_sel_s = (rd_idx == IDX_W'(i)) ? slot_q[i] : rd_sel_s;
        end
    end

    assign hit_s     = slot_hit(scan_sel_s, new_r.score);
    assign ins_hit_s = (state_r == ST_INSERT) && (pos_r < N_IDX);

    genvar g;
    generate
        for (g = 0; g < N_ENTRIES; g++) begin : g_slot
            if (g == 0) begin : g_head
                assign above_s[g] = '0;
            end else begin : g_body
                assign above_s[g] = slot_q[g-1];
            end
            // Slots below the insert point move down; the bottom entry falls off the end.
            assign load_en_s[g]  = ins_hit_s && (pos_r == IDX_W'(g));
            assign shift_en_s[g] = ins_hit_s && (pos_r <  IDX_W'(g));

            scoreboard_slot u_slot (
                .clk       (clk),
                .rst       (rst),
                .clr       (clr_s),
                .load_en   (load_en_s[g]),
                .shift_en  (shift_en_s[g]),
                .above     (above_s[g]),
                .new_entry (new_r),
                .entry     (slot_q[g])
            );
        end
    endgenerate

    // Control FSM with its registered handshake and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            pos_r      <= '0;
            new_r      <= '0;
            in_ready_r <= 1'b0;
            ins_done_r <= 1'b0;
            ins_rank_r <= '0;
        end else if (clr_s) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            pos_r      <= '0;
            in_ready_r <= 1'b1;
            ins_done_r <= 1'b0;
            ins_rank_r <= '0;
        end else begin
            ins_done_r <= 1'b0;
            ins_rank_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        new_r      <= '{valid: 1'b1,
                                        userid: SB_UID_W'(in_userid),
                                        score: SB_SCORE_W'(in_score)};
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SCAN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        pos_r   <= idx_r;
                        state_r <= ST_INSERT;
                    end else if (idx_r == LAST_IDX) begin
                        pos_r   <= N_IDX;
                        state_r <= ST_INSERT;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                ST_INSERT: begin
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    ins_done_r <= 1'b1;
                    ins_rank_r <= pos_r;
                    in_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered read port; sees the table as it stood before the current edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_r  <= 1'b0;
            rd_score_r  <= '0;
            rd_userid_r <= '0;
        end else if ((rd_idx < N_IDX) && rd_sel_s.valid) begin
            rd_valid_r  <= 1'b1;
            rd_score_r  <= SCORE_W'(rd_sel_s.score);
            rd_userid_r <= UID_W'(rd_sel_s.userid);
        end else begin
            rd_valid_r  <= 1'b0;
            rd_score_r  <= '0;
            rd_userid_r <= '0;
        end
    end

    assign in_ready  = in_ready_r;
    assign ins_done  = ins_done_r;
    assign ins_rank  = ins_rank_r;
    assign rd_valid  = rd_valid_r;
    assign rd_score  = rd_score_r;
    assign rd_userid = rd_userid_r;

endmodule

// File: tb/tb_scoreboard_ranker.sv
// Bench for scoreboard_ranker: directed vector table, corner sequences and a queue-based random model.
module tb_scoreboard_ranker;

    localparam int N     = 4;
    localparam int IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
`ifdef SCOREBOARD_CLEAR_EN
    logic        clr = 1'b0;
`endif
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_score  = 32'd0;
    logic [15:0] in_userid = 16'd0;
    logic        ins_done;
    logic [3:0]  ins_rank;
    logic [3:0]  rd_idx    = 4'd0;
    logic        rd_valid;
    logic [31:0] rd_score;
    logic [15:0] rd_userid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_score[$];
    logic [15:0] m_uid[$];

    scoreboard_ranker #(.N_ENTRIES(N), .SCORE_W(32), .UID_W(16), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SCOREBOARD_CLEAR_EN
        .clr       (clr),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .in_userid (in_userid),
        .ins_done  (ins_done),
        .ins_rank  (ins_rank),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_score  (rd_score),
        .rd_userid (rd_userid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] uid;
        logic [31:0] score;
        int          exp_rank;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: insert before the first strictly lower score, keep at most N entries.
    function automatic int model_insert(input logic [15:0] uid, input logic [31:0] score);
        int pos;
        pos = m_score.size();
        for (int i = 0; i < m_score.size(); i++) begin
            if (score > m_score[i]) begin
                pos = i;
                break;
            end
        end
        if (pos >= N) return N;
        m_score.insert(pos, score);
        m_uid.insert(pos, uid);
        if (m_score.size() > N) begin
            void'(m_score.pop_back());
            void'(m_uid.pop_back());
        end
        return pos;
    endfunction

    function automatic int model_latency(input int rank);
        return (rank == N) ? N + 2 : rank + 3;
    endfunction

    task automatic read_slot(input int idx, output logic v, output logic [31:0] s, output logic [15:0] u);
        @(negedge clk);
        rd_idx = idx[3:0];
        @(posedge clk);
        #1;
        v = rd_valid;
        s = rd_score;
        u = rd_userid;
    endtask

    task automatic check_table(input string tag);
        logic        v;
        logic [31:0] s;
        logic [15:0] u;
        for (int i = 0; i <= N; i++) begin
            read_slot(i, v, s, u);
            if (i < m_score.size()) begin
                chk($sformatf("%s slot%0d valid", tag, i), {63'd0, v}, 64'd1);
                chk($sformatf("%s slot%0d score", tag, i), {32'd0, s}, {32'd0, m_score[i]});
                chk($sformatf("%s slot%0d uid", tag, i), {48'd0, u}, {48'd0, m_uid[i]});
            end else begin
                chk($sformatf("%s slot%0d empty", tag, i), {15'd0, v, s, u}, 64'd0);
            end
        end
        read_slot(15, v, s, u);
        chk($sformatf("%s idx15 empty", tag), {15'd0, v, s, u}, 64'd0);
    endtask

    task automatic do_insert(input logic [15:0] uid, input logic [31:0] score, input bit hold,
                             output int rank, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready before accept", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_userid = uid;
        in_score  = score;
        @(posedge clk);
        #1;
        if (hold) in_score = ~score;
        else      in_valid = 1'b0;
        chk("in_ready after accept", {63'd0, in_ready}, 64'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!ins_done) chk("in_ready while busy", {63'd0, in_ready}, 64'd0);
        end while (!ins_done && lat < 40);
        chk("ins_done seen", {63'd0, ins_done}, 64'd1);
        rank = int'(ins_rank);
        chk("in_ready back in idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ins_done single pulse", {63'd0, ins_done}, 64'd0);
        chk("no second transfer", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_insert(input string tag, input logic [15:0] uid, input logic [31:0] score,
                              input bit hold, output int rank);
        int exp_rank;
        int lat;
        exp_rank = model_insert(uid, score);
        do_insert(uid, score, hold, rank, lat);
        chk({tag, " rank"}, 64'(rank), 64'(exp_rank));
        chk({tag, " latency"}, 64'(lat), 64'(model_latency(exp_rank)));
    endtask

    initial begin
        int          rank;
        int          seen;
        logic        v;
        logic [31:0] s;
        logic [15:0] u;

        vecs[0] = '{16'h0011, 32'd100, 0};
        vecs[1] = '{16'h0101, 32'd50,  1};
        vecs[2] = '{16'h0102, 32'd200, 0};
        vecs[3] = '{16'h0103, 32'd150, 1};
        vecs[4] = '{16'h0104, 32'd10,  4};
        vecs[5] = '{16'h0105, 32'd120, 2};
        vecs[6] = '{16'h0022, 32'd200, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {in_ready, ins_done, ins_rank, rd_valid, rd_score, rd_userid},
            {1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 16'd0});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready first edge after reset", {63'd0, in_ready}, 64'd1);

        // Directed vectors: spec ranks plus model cross-check of latency and contents
        for (int k = 0; k < 7; k++) begin
            run_insert($sformatf("vec%0d", k), vecs[k].uid, vecs[k].score, 1'b0, rank);
            chk($sformatf("vec%0d spec rank", k), 64'(rank), 64'(vecs[k].exp_rank));
            check_table($sformatf("vec%0d", k));
            if (k == 3) begin
                read_slot(0, v, s, u); chk("ordered slot0", {32'd0, s}, 64'd200);
                read_slot(1, v, s, u); chk("ordered slot1", {32'd0, s}, 64'd150);
                read_slot(2, v, s, u); chk("ordered slot2", {32'd0, s}, 64'd100);
                read_slot(3, v, s, u); chk("ordered slot3", {32'd0, s}, 64'd50);
            end
        end
        read_slot(0, v, s, u);
        chk("tie keeps incumbent uid", {48'd0, u}, 64'h0102);

        // in_valid held through an insert, payload changed after accept
        run_insert("hold", 16'h0033, 32'd175, 1'b1, rank);
        check_table("hold");

        // Abort during SCAN
        @(negedge clk);
        in_valid  = 1'b1;
        in_userid = 16'h0044;
        in_score  = 32'd500;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
`ifdef SCOREBOARD_CLEAR_EN
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
`else
        rst = 1'b0;
        #2;
        chk("outputs during reset", {63'd0, in_ready | ins_done | rd_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
`endif
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (ins_done) seen = 1;
        end
        chk("no ins_done after abort", 64'(seen), 64'd0);
        m_score.delete();
        m_uid.delete();
        check_table("after abort");
        run_insert("post abort", 16'h0055, 32'd3, 1'b0, rank);
        chk("post abort rank 0", 64'(rank), 64'd0);

        // Randomized inserts with a narrow score range to exercise ties and drops
        for (int r = 0; r < 30; r++) begin
            run_insert($sformatf("rand%0d", r), 16'($urandom), 32'($urandom_range(0, 15)), r[2], rank);
            check_table($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
